// File: rtl/serial_ctrl_pkg.sv
// Shared constants for the word-level serial adder sequencer.
package serial_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/serial_add.sv
// Bit-serial full adder: combinational sum, registered carry for the next bit slice.
module serial_add (
   input  logic clk,
   input  logic reset,
   input  logic A,
   input  logic B,
   input  logic st_in,
   output logic sum,
   output logic st
);

   assign sum = A ^ B ^ st_in;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) st <= 1'b0;
      else        st <= (A & B) | (st_in & (A ^ B));
   end

endmodule

// File: rtl/serial_add_ctrl.sv
// Word-level sequencer around serial_add: streams operands LSB-first and
// reassembles the sum with carry-out behind two valid/ready handshakes.
//
//   state    | meaning
//   ST_IDLE  | waiting for an operand pair, in_ready high
//   ST_SHIFT | one bit slice per cycle through serial_add
//   ST_DONE  | result presented, waiting for out_ready
module serial_add_ctrl
   import serial_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic [WIDTH-1:0] sum_nxt;
   logic             cin_q;
   logic             shifting;
   logic             last;
   logic             add_a;
   logic             add_b;
   logic             add_st_in;
   logic             add_sum;
   logic             add_st;
   logic             carry;

   assign shifting  = (state == ST_SHIFT);
   assign last      = (cnt == CNT_W'(WIDTH - 1));
   assign in_ready  = (state == ST_IDLE);
   assign busy      = (state == ST_SHIFT) || (state == ST_DONE);

   // Bit 0 takes the word's carry-in; the adder's leftover carry from the previous word is never used.
   assign add_a     = shifting & a_sr[0];
   assign add_b     = shifting & b_sr[0];
   assign add_st_in = shifting & ((cnt == '0) ? cin_q : add_st);
   assign carry     = (add_a & add_b) | (add_st_in & (add_a ^ add_b));

   generate
      if (WIDTH == 1) begin : g_w1
         assign sum_nxt = add_sum;
      end else begin : g_wn
         assign sum_nxt = {add_sum, sum_sr[WIDTH-1:1]};
      end
   endgenerate

   serial_add u_serial_add (
      .clk   (clk),
      .reset (reset),
      .A     (add_a),
      .B     (add_b),
      .st_in (add_st_in),
      .sum   (add_sum),
      .st    (add_st)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         a_sr      <= '0;
         b_sr      <= '0;
         sum_sr    <= '0;
         cin_q     <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_sr  <= in_a;
                  b_sr  <= in_b;
                  cin_q <= in_cin;
                  cnt   <= '0;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= sum_nxt;
               cnt    <= cnt + CNT_W'(1);
               if (last) begin
                  out_sum   <= sum_nxt;
                  out_cout  <= carry;
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 with directed operand vectors.
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_a = '0;
   logic [7:0] in_b = '0;
   logic       in_cin = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_sum;
   logic       out_cout;
   logic       busy;

   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         acc_cyc = 0;
   logic       prev_ov = 1'b0;
   logic [8:0] exp_q[$];

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: latency on out_valid rise, scoreboard pop on each output handshake.
   always @(negedge clk) begin
      if (!reset) begin
         prev_ov = 1'b0;
      end else begin
         if (in_valid && in_ready) acc_cyc = cyc + 1;
         if (out_valid && !prev_ov) check("latency", cyc - acc_cyc, 8);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_out: got sum 0x%0h cout %0d expected no result", out_sum, out_cout);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               check("out_sum", int'(out_sum), int'(e[7:0]));
               check("out_cout", int'(out_cout), int'(e[8]));
            end
         end
         prev_ov = out_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic push, input logic [8:0] exp);
      int t = 0;
      while (!in_ready && t < 100) begin
         tick();
         t++;
      end
      check("in_ready_wait", int'(in_ready), 1);
      in_a = a;
      in_b = b;
      in_cin = cin;
      in_valid = 1'b1;
      if (push) exp_q.push_back(exp);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || busy) && t < 200) begin
         tick();
         t++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   initial begin
      // 1: reset values
      #12;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_sum", int'(out_sum), 0);
      check("rst_out_cout", int'(out_cout), 0);
      check("rst_busy", int'(busy), 0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      check("rst_in_ready", int'(in_ready), 1);

      // 2..4: basic sums, wrap-around, back-to-back carry isolation
      send(8'h03, 8'h01, 1'b0, 1'b1, {1'b0, 8'h04});
      drain();
      send(8'hFF, 8'h01, 1'b0, 1'b1, {1'b1, 8'h00});
      drain();
      send(8'hFF, 8'hFF, 1'b1, 1'b1, {1'b1, 8'hFF});
      send(8'h00, 8'h00, 1'b0, 1'b1, {1'b0, 8'h00});
      drain();

      // 5: output stall with new operands pending
      out_ready = 1'b0;
      send(8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 8'h0C});
      begin
         int t = 0;
         while (!out_valid && t < 50) begin
            tick();
            t++;
         end
      end
      check("stall_valid_seen", int'(out_valid), 1);
      in_b = 8'h80;
      in_cin = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_a = 8'h80 + 8'(i);
         @(negedge clk);
         check("stall_sum", int'(out_sum), 8'h0C);
         check("stall_in_ready", int'(in_ready), 0);
         check("stall_out_valid", int'(out_valid), 1);
         tick();
      end
      exp_q.push_back({1'b1, 8'h04});
      out_ready = 1'b1;
      tick();
      check("post_hs_in_ready", int'(in_ready), 1);
      check("post_hs_busy", int'(busy), 0);
      tick();
      in_valid = 1'b0;
      check("accept_busy", int'(busy), 1);
      check("accept_in_ready", int'(in_ready), 0);
      drain();

      // 6: reset mid-SHIFT at cnt==3 discards the word
      send(8'h5A, 8'h3C, 1'b1, 1'b0, 9'h0);
      tick();
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_out_sum", int'(out_sum), 0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      send(8'h10, 8'h20, 1'b1, 1'b1, {1'b0, 8'h31});
      drain();
      repeat (12) tick();
      check("final_queue", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
